out_port_fifo: RTL
==================

OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, output data width.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_ena, input, 1, CPU OUT-instruction write strobe.
REQ-007 SHALL have port wr_data, input, DATA_WIDTH, CPU out_data value.
REQ-008 SHALL have port full_out, output, 1, FIFO full; the CPU stalls fetch on this.
REQ-009 SHALL have port out_valid, output, 1, head entry available to the consumer.
REQ-010 SHALL have port out_data, output, DATA_WIDTH, head entry.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the head entry.
REQ-012 SHALL have port level_out, output, $clog2(DEPTH)+1, current entry count.
REQ-013 SHALL have port overflow_out, output, 1, sticky dropped-write flag.
REQ-014 SHALL have port clr_overflow, input, 1, clears overflow_out.

Function
REQ-015 SHALL pop on the clk edge where out_valid and out_ready are both 1.
REQ-016 SHALL push wr_data on the clk edge where wr_ena is 1 and the FIFO is not full, or is full and a pop occurs in the same cycle.
REQ-017 SHALL, on a simultaneous push and pop, leave level unchanged and order preserved; when empty, only the push takes effect (no pop).
REQ-018 SHALL drop a write when wr_ena=1, the FIFO is full and no pop occurs; contents and level stay unchanged and overflow_out is set on that edge.
REQ-019 SHALL ignore out_ready while empty: no pointer move and no underflow.
REQ-020 SHALL use read and write pointers of $clog2(DEPTH)+1 bits that wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-021 SHALL provide first-word fall-through: an entry written at edge k gives out_valid=1 and out_data equal to that entry after edge k; write-to-valid latency is 1 edge.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive full_out, out_valid and level_out as registered-state decodes with no combinational path from out_ready or wr_ena.
REQ-024 SHALL have clr_overflow take priority over a same-cycle overflow event, leaving overflow_out=0.
REQ-025 SHALL make out_data a don't-care while out_valid=0; the bench SHALL NOT check it then.

Reset
REQ-026 SHALL, while rst=0, asynchronously clear pointers, level_out=0, out_valid=0, full_out=0 and overflow_out=0; storage contents are not reset.
REQ-027 SHALL, if reset is asserted mid-transfer, discard all pending entries, with the first post-reset push landing at entry 0.

Configuration
REQ-028 SHALL, with macro OUT_PORT_OVF_CNT_EN defined, add output ovf_cnt_out (8 bits, reset 0) that increments per dropped write, saturates at 255 and is cleared by clr_overflow.
REQ-029 SHALL, without OUT_PORT_OVF_CNT_EN, have no port ovf_cnt_out and no counter logic, with all other behaviour identical.

Structure
REQ-030 SHALL take DATA_WIDTH, OUT_FIFO_DEPTH and typedef data_t from shared package cpu_pkg, shared with the CPU top.
REQ-031 SHALL implement storage as sub-module out_port_mem: a DEPTH x DATA_WIDTH register array with synchronous write and asynchronous read, no reset.

Verification
REQ-032 SHALL verify: push 0x11, 0x22, 0x33 with out_ready=0 -> level_out=3, out_valid=1, out_data=0x11; then out_ready=1 for 3 cycles -> pops 0x11, 0x22, 0x33 and level_out=0.
REQ-033 SHALL verify: 8 pushes (DEPTH=8) -> full_out=1; ninth push 0x99 -> dropped, overflow_out=1, level_out stays 8, head still first value.
REQ-034 SHALL verify: full FIFO with wr_ena=1, wr_data=0xAA and out_ready=1 -> pop plus push, level_out stays 8, 0xAA emerges last.
REQ-035 SHALL verify: 20 push/pop cycles -> pointer wrap-around with data order preserved; out_ready=1 while empty -> level_out stays 0.
REQ-036 SHALL verify: rst=0 asserted off-edge with level 5 -> outputs clear immediately; after release, push 0x5A -> out_data=0x5A.
REQ-037 SHALL verify, with OUT_PORT_OVF_CNT_EN defined: 300 dropped writes -> ovf_cnt_out=255; clr_overflow -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Package : cpu_pkg
// Brief   : Shared CPU-level widths and types for the output port path.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int OUT_FIFO_DEPTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/out_port_mem.sv
// ============================================================================
// Module : out_port_mem
// Brief  : DEPTH x DATA_WIDTH register array, synchronous write, async read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_port_mem #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int DEPTH      = cpu_pkg::OUT_FIFO_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Storage is deliberately not reset; validity is tracked by the pointers.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : out_port_mem

`default_nettype wire

// File: rtl/out_port_fifo.sv
// ============================================================================
// Module : out_port_fifo
// Brief  : First-word fall-through FIFO between the CPU OUT instruction and
//          the output-port consumer, with sticky overflow flag.
//          Define OUT_PORT_OVF_CNT_EN to add the saturating ovf_cnt_out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_port_fifo #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int DEPTH      = cpu_pkg::OUT_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_ena,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full_out,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level_out,
  output logic                       overflow_out,
  input  logic                       clr_overflow
`ifdef OUT_PORT_OVF_CNT_EN
  ,
  output logic [7:0]                 ovf_cnt_out
`endif
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_ptr_w  = c_addr_w + 1;

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic               r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                   (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

  assign w_pop  = !w_empty && out_ready;
  assign w_push = wr_ena && (!w_full || w_pop);
  assign w_drop = wr_ena && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // A clear in the same cycle as a drop wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  out_port_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (c_addr_w)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr[c_addr_w-1:0]),
    .wr_data (wr_data),
    .rd_addr (r_rd_ptr[c_addr_w-1:0]),
    .rd_data (out_data)
  );

  assign full_out     = w_full;
  assign out_valid    = !w_empty;
  assign level_out    = r_wr_ptr - r_rd_ptr;
  assign overflow_out = r_overflow;

`ifdef OUT_PORT_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf_cnt <= 8'd0;
    end else if (clr_overflow) begin
      r_ovf_cnt <= 8'd0;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt_out = r_ovf_cnt;
`endif

endmodule : out_port_fifo

`default_nettype wire
